adc_capture_ctrl: RTL and testbench

Parametrised capture controller for the AD9643 datapath. Takes per-channel samples already deserialised into the AXI clock domain, packs them into AXI4-Stream beats framed by a programmable length with `tlast`, and counts samples dropped under backpressure. It exposes an AXI4-Lite register bank for control, status and identification. It sits between the LVDS capture/CDC stage and the stream consumer in the block design.

---
 rtl/adc_capture_pkg.sv | 42 ++++
 rtl/axil_regs.sv | 129 ++++++++++++
 rtl/adc_capture_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_capture_pkg.sv
// Shared constants, register map and types for the AD9643 capture controller.
package adc_capture_pkg;

  localparam logic [1:0] REG_CTRL      = 2'd0;
  localparam logic [1:0] REG_FRAME_LEN = 2'd1;
  localparam logic [1:0] REG_STATUS    = 2'd2;
  localparam logic [1:0] REG_ID        = 2'd3;

  localparam int unsigned CTRL_ENABLE  = 0;
  localparam int unsigned CTRL_MODE    = 1;
  localparam int unsigned CTRL_ARM     = 2;
  localparam int unsigned CTRL_TEST    = 3;
  localparam int unsigned CTRL_CLR_OVF = 4;

  localparam int unsigned STATUS_BUSY    = 0;
  localparam int unsigned STATUS_DONE    = 1;
  localparam int unsigned STATUS_OVF_LSB = 16;

  localparam int unsigned OVF_W  = 16;
  localparam int unsigned LANE_W = 16;

  localparam logic [15:0] ID_BASE = 16'hAD96;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Field order mirrors CTRL bits [4:0]; arm and clr_ovf are single-cycle strobes.
  typedef struct packed {
    logic clr_ovf;
    logic test;
    logic arm;
    logic mode;
    logic enable;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/axil_regs.sv
// AXI4-Lite slave with the CTRL/FRAME_LEN/STATUS/ID register bank.
module axil_regs
  import adc_capture_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 14,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic              busy,
  input  logic              done,
  input  logic [OVF_W-1:0]  ovf_cnt,
  output ctrl_t             ctrl,
  output logic [LEN_W-1:0]  frame_len
);

  logic        wr_fire;
  logic        rd_fire;
  logic        wr_unmapped;
  logic        rd_unmapped;
  logic [1:0]  wr_sel;
  logic [1:0]  rd_sel;
  logic [31:0] rd_word;
  logic        unused;

  // Byte lanes are not supported and the low address bits are always word-aligned.
  assign unused = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_fire     = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign rd_fire     = s_axi_arready & s_axi_arvalid;
  assign wr_unmapped = |(s_axi_awaddr >> 4);
  assign rd_unmapped = |(s_axi_araddr >> 4);
  assign wr_sel      = s_axi_awaddr[3:2];
  assign rd_sel      = s_axi_araddr[3:2];

  // Write channel and register file; arm/clr_ovf self-clear after one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      ctrl          <= '0;
      frame_len     <= '0;
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      ctrl.arm      <= 1'b0;
      ctrl.clr_ovf  <= 1'b0;
      if (!s_axi_bvalid && !s_axi_awready && s_axi_awvalid && s_axi_wvalid) begin
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end
      if (wr_fire) begin
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_unmapped ? RESP_SLVERR : RESP_OKAY;
        if (!wr_unmapped) begin
          case (wr_sel)
            REG_CTRL:      ctrl      <= ctrl_t'(s_axi_wdata[4:0]);
            REG_FRAME_LEN: frame_len <= s_axi_wdata[LEN_W-1:0];
            default:       ;
          endcase
        end
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    case (rd_sel)
      REG_CTRL: begin
        rd_word[CTRL_ENABLE] = ctrl.enable;
        rd_word[CTRL_MODE]   = ctrl.mode;
        rd_word[CTRL_TEST]   = ctrl.test;
      end
      REG_FRAME_LEN: rd_word[LEN_W-1:0] = frame_len;
      REG_STATUS: begin
        rd_word[STATUS_BUSY]                = busy;
        rd_word[STATUS_DONE]                = done;
        rd_word[STATUS_OVF_LSB +: OVF_W]    = ovf_cnt;
      end
      default: rd_word = {ID_BASE, 8'(NUM_CH), 8'(SAMPLE_W)};
    endcase
  end

  // Read channel: STATUS is sampled at the address handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      s_axi_arready <= 1'b0;
      if (!s_axi_rvalid && !s_axi_arready && s_axi_arvalid) begin
        s_axi_arready <= 1'b1;
      end
      if (rd_fire) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_unmapped ? 32'd0 : rd_word;
        s_axi_rresp  <= rd_unmapped ? RESP_SLVERR : RESP_OKAY;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture controller: frames ADC samples into AXI4-Stream beats with tlast,
// counts samples lost to backpressure, and hosts the AXI4-Lite register bank.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned SAMPLE_W = 14,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic [ADDR_W-1:0]          s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [31:0]                s_axi_wdata,
  input  logic [3:0]                 s_axi_wstrb,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [ADDR_W-1:0]          s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [31:0]                s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic                       sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
  output logic [NUM_CH*LANE_W-1:0]   m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
);

  localparam int unsigned TDATA_W = NUM_CH * LANE_W;

  ctrl_t                       ctrl;
  logic [LEN_W-1:0]            frame_len;
  state_t                      state;
  state_t                      state_next;
  logic [LEN_W-1:0]            beat_cnt;
  logic [LEN_W-1:0]            last_idx;
  logic [SAMPLE_W-1:0]         ramp;
  logic [OVF_W-1:0]            ovf_cnt;
  logic                        done;
  logic                        busy;
  logic                        can_load;
  logic                        is_last;
  logic                        start;
  logic                        capture;
  logic                        drop;
  logic                        finish;
  logic signed [SAMPLE_W-1:0]  smp;
  logic [TDATA_W-1:0]          lanes;

  axil_regs #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W),
    .LEN_W    (LEN_W),
    .ADDR_W   (ADDR_W)
  ) u_regs (
    .clk           (s_axi_aclk),
    .rst_n         (s_axi_aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .busy          (busy),
    .done          (done),
    .ovf_cnt       (ovf_cnt),
    .ctrl          (ctrl),
    .frame_len     (frame_len)
  );

  assign busy     = (state != ST_IDLE);
  assign can_load = !m_axis_tvalid || m_axis_tready;
  assign is_last  = (beat_cnt == last_idx);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state <= ST_IDLE;
    else                state <= state_next;
  end

  // Frames end only on a captured tlast beat, so clearing enable never truncates.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    drop       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl.enable && (!ctrl.mode || ctrl.arm)) begin
          state_next = ST_STREAM;
          start      = 1'b1;
        end
      end
      ST_STREAM: begin
        if (sample_valid) begin
          if (can_load) begin
            capture = 1'b1;
            if (is_last && (ctrl.mode || !ctrl.enable)) state_next = ST_DRAIN;
          end else begin
            drop = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (!m_axis_tvalid) begin
          state_next = ST_IDLE;
          finish     = ctrl.mode;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-lane source select and sign extension to 16 bits.
  always_comb begin
    lanes = '0;
    smp   = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      smp = ctrl.test ? ramp + SAMPLE_W'(k) : sample_data[k*SAMPLE_W +: SAMPLE_W];
      lanes[k*LANE_W +: LANE_W] = LANE_W'(smp);
    end
  end

  // Frame length of 0 is treated as 1, i.e. every beat is a tlast beat.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      beat_cnt <= '0;
      last_idx <= '0;
      ramp     <= '0;
    end else if (start) begin
      beat_cnt <= '0;
      last_idx <= (frame_len == '0) ? '0 : frame_len - LEN_W'(1);
      ramp     <= '0;
    end else if (capture) begin
      beat_cnt <= is_last ? '0 : beat_cnt + LEN_W'(1);
      ramp     <= ramp + SAMPLE_W'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (capture) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= lanes;
      m_axis_tlast  <= is_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Overflow counter saturates; a coincident clear takes priority.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      ovf_cnt <= '0;
    end else if (ctrl.clr_ovf) begin
      ovf_cnt <= '0;
    end else if (drop && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + OVF_W'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      done <= 1'b0;
    end else if (finish) begin
      done <= 1'b1;
    end else if (ctrl.arm && (state == ST_IDLE)) begin
      done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed self-checking bench for adc_capture_ctrl (NUM_CH=2, SAMPLE_W=14).
module tb_adc_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [4:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        sample_valid;
  logic [27:0] sample_data;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  int n_cmp = 0;
  int n_bad = 0;

  adc_capture_ctrl #(
    .NUM_CH   (2),
    .SAMPLE_W (14),
    .LEN_W    (16),
    .ADDR_W   (5)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (rst_n),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [1:0] exp_resp, input string tag);
    int n;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 20) begin tick(); n++; end
    if (!s_axi_awready) begin
      check({tag, "_awready_timeout"}, 32'(s_axi_awready), 32'd1);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      return;
    end
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    check({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
    check({tag, "_bresp"}, 32'(s_axi_bresp), 32'(exp_resp));
    tick();
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    int n;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    if (!s_axi_arready) begin
      check({tag, "_arready_timeout"}, 32'(s_axi_arready), 32'd1);
      s_axi_arvalid = 1'b0;
      return;
    end
    tick();
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin tick(); n++; end
    check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
    check({tag, "_rdata"}, s_axi_rdata, exp_data);
    check({tag, "_rresp"}, 32'(s_axi_rresp), 32'(exp_resp));
    tick();
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = 4'hF;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1; sample_valid = 1'b0; sample_data = '0; m_axis_tready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid",  32'(m_axis_tvalid), 32'd0);
    check("rst_tlast",   32'(m_axis_tlast),  32'd0);
    check("rst_tdata",   m_axis_tdata,       32'd0);
    check("rst_awready", 32'(s_axi_awready), 32'd0);
    check("rst_wready",  32'(s_axi_wready),  32'd0);
    check("rst_arready", 32'(s_axi_arready), 32'd0);
    check("rst_bvalid",  32'(s_axi_bvalid),  32'd0);
    check("rst_rvalid",  32'(s_axi_rvalid),  32'd0);
    rst_n = 1'b1;
    tick(); tick();
    axi_read(5'h00, 32'h0, 2'b00, "rst_ctrl");
    axi_read(5'h08, 32'h0, 2'b00, "rst_status");

    // Register access
    axi_write(5'h04, 32'h5, 2'b00, "wr_len5");
    axi_read(5'h04, 32'h0000_0005, 2'b00, "rd_len5");
    axi_read(5'h0C, 32'hAD96_020E, 2'b00, "rd_id");
    axi_read(5'h10, 32'h0, 2'b10, "rd_unmapped");
    axi_write(5'h10, 32'hFFFF_FFFF, 2'b10, "wr_unmapped");
    axi_write(5'h08, 32'hFFFF_FFFF, 2'b00, "wr_status_ro");
    axi_read(5'h08, 32'h0, 2'b00, "rd_status_ro");
    axi_read(5'h00, 32'h0, 2'b00, "rd_ctrl_after_unmapped");

    // Continuous ramp capture, frame length 4
    axi_write(5'h04, 32'h4, 2'b00, "wr_len4");
    axi_write(5'h00, 32'h9, 2'b00, "wr_ctrl_cont");
    sample_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("cont_tvalid%0d", i), 32'(m_axis_tvalid), 32'd1);
      check($sformatf("cont_tdata%0d", i), m_axis_tdata, {16'(i + 1), 16'(i)});
      check($sformatf("cont_tlast%0d", i), 32'(m_axis_tlast), 32'((i % 4) == 3));
    end
    sample_valid = 1'b0;
    axi_write(5'h00, 32'h8, 2'b00, "wr_ctrl_cont_off");
    sample_valid = 1'b1;
    for (int i = 12; i < 16; i++) begin
      tick();
      check($sformatf("cont_tail_tdata%0d", i), m_axis_tdata, {16'(i + 1), 16'(i)});
      check($sformatf("cont_tail_tlast%0d", i), 32'(m_axis_tlast), 32'(i == 15));
    end
    sample_valid = 1'b0;
    repeat (3) tick();
    axi_read(5'h08, 32'h0, 2'b00, "cont_status_idle");

    // Single frame of 3 beats
    axi_write(5'h04, 32'h3, 2'b00, "wr_len3");
    axi_write(5'h00, 32'hB, 2'b00, "wr_ctrl_single");
    sample_valid = 1'b1;
    axi_write(5'h00, 32'hF, 2'b00, "wr_ctrl_arm");
    check("single_pre_tvalid", 32'(m_axis_tvalid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("single_tvalid%0d", i), 32'(m_axis_tvalid), 32'd1);
      check($sformatf("single_tdata%0d", i), m_axis_tdata, {16'(i + 1), 16'(i)});
      check($sformatf("single_tlast%0d", i), 32'(m_axis_tlast), 32'(i == 2));
    end
    seen = 0;
    repeat (6) begin tick(); seen += int'(m_axis_tvalid); end
    check("single_no_extra", 32'(seen), 32'd0);
    axi_read(5'h08, 32'h0000_0002, 2'b00, "single_status_done");
    axi_read(5'h00, 32'h0000_000B, 2'b00, "single_ctrl_rb");
    sample_valid = 1'b0;

    // Backpressure: 10 samples against a stalled sink
    axi_write(5'h00, 32'hF, 2'b00, "wr_ctrl_rearm");
    m_axis_tready = 1'b0;
    sample_valid = 1'b1;
    repeat (10) tick();
    sample_valid = 1'b0;
    check("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
    check("bp_tdata",  m_axis_tdata,       32'h0001_0000);
    check("bp_tlast",  32'(m_axis_tlast),  32'd0);
    axi_read(5'h08, 32'h0009_0001, 2'b00, "bp_status_ovf9");
    axi_write(5'h00, 32'h1B, 2'b00, "wr_ctrl_clr_ovf");
    axi_read(5'h08, 32'h0000_0001, 2'b00, "bp_status_cleared");
    m_axis_tready = 1'b1;
    sample_valid = 1'b1;
    tick();
    check("bp_resume_tdata1", m_axis_tdata, 32'h0002_0001);
    check("bp_resume_tlast1", 32'(m_axis_tlast), 32'd0);
    tick();
    sample_valid = 1'b0;
    check("bp_resume_tdata2", m_axis_tdata, 32'h0003_0002);
    check("bp_resume_tlast2", 32'(m_axis_tlast), 32'd1);
    repeat (3) tick();
    axi_read(5'h08, 32'h0000_0002, 2'b00, "bp_status_done");

    // Disable mid-frame, sign extension
    axi_write(5'h00, 32'h0, 2'b00, "wr_ctrl_off");
    axi_write(5'h04, 32'h8, 2'b00, "wr_len8");
    sample_data = {14'h0005, 14'h2000};
    axi_write(5'h00, 32'h1, 2'b00, "wr_ctrl_adc");
    sample_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("dis_tdata%0d", i), m_axis_tdata, 32'h0005_E000);
      check($sformatf("dis_tlast%0d", i), 32'(m_axis_tlast), 32'd0);
    end
    sample_valid = 1'b0;
    axi_write(5'h00, 32'h0, 2'b00, "wr_ctrl_disable");
    sample_data = {14'h3FFF, 14'h1FFF};
    sample_valid = 1'b1;
    for (int i = 3; i < 8; i++) begin
      tick();
      check($sformatf("dis_tvalid%0d", i), 32'(m_axis_tvalid), 32'd1);
      check($sformatf("dis_tdata%0d", i), m_axis_tdata, 32'hFFFF_1FFF);
      check($sformatf("dis_tlast%0d", i), 32'(m_axis_tlast), 32'(i == 7));
    end
    sample_valid = 1'b0;
    repeat (3) tick();
    axi_read(5'h08, 32'h0000_0002, 2'b00, "dis_status_idle");
    sample_valid = 1'b1;
    seen = 0;
    repeat (3) begin tick(); seen += int'(m_axis_tvalid); end
    sample_valid = 1'b0;
    check("dis_no_restart", 32'(seen), 32'd0);

    // Reset asserted mid-frame
    axi_write(5'h00, 32'h1, 2'b00, "wr_ctrl_pre_reset");
    sample_valid = 1'b1;
    repeat (3) tick();
    check("prerst_tvalid", 32'(m_axis_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("midrst_tlast",  32'(m_axis_tlast),  32'd0);
    check("midrst_tdata",  m_axis_tdata,       32'd0);
    sample_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    axi_read(5'h00, 32'h0, 2'b00, "postrst_ctrl");
    axi_read(5'h08, 32'h0, 2'b00, "postrst_status");
    axi_read(5'h04, 32'h0, 2'b00, "postrst_len");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
